// File: rtl/rr_bus_arbiter4.sv
// Four-requester round-robin arbiter owning the select of a shared 4:1 result mux.
// A grant streams beats under valid/ready until last, withdrawal or burst budget.
module rr_bus_arbiter4 #(
  parameter int DW    = 16,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [3:0]    last,
  input  logic [DW-1:0] i0,
  input  logic [DW-1:0] i1,
  input  logic [DW-1:0] i2,
  input  logic [DW-1:0] i3,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  output logic [3:0]    ack,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic          busy
);

  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [1:0]    pick;
  logic [1:0]    idx;
  logic          xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // The mux follows the registered select only, so o_data stays stable through stalls.
  always_comb begin
    unique case (sel_q)
      2'd0:    o_data = i0;
      2'd1:    o_data = i1;
      2'd2:    o_data = i2;
      default: o_data = i3;
    endcase
  end

  assign busy    = (state_q == GRANT);
  assign o_valid = busy & req[sel_q];
  assign xfer    = o_valid & o_ready;
  assign ack     = gnt_q & {4{xfer}};
  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign cnt_inc = cnt_q + CW'(1);

  // Scan from the highest offset down so the closest requester after ptr wins.
  always_comb begin
    pick = ptr_q;
    idx  = ptr_q;
    for (int j = 3; j >= 0; j--) begin
      idx = ptr_q + 2'(j);
      if (req[idx]) pick = idx;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          sel_d   = pick;
          gnt_d   = 4'b0001 << pick;
          cnt_d   = '0;
        end
      end
      default: begin
        if (!req[sel_q] || (xfer && (last[sel_q] || cnt_inc == CW'(BURST)))) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = sel_q + 2'd1;
        end else if (xfer) begin
          cnt_d = cnt_inc;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_rr_bus_arbiter4.sv
// Randomized bench for rr_bus_arbiter4 against a cycle-level owner/beats/pointer model.
module tb_rr_bus_arbiter4;
  localparam int DW    = 16;
  localparam int BURST = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [3:0]         req, last;
  logic [3:0][DW-1:0] din;
  logic               o_ready;
  logic [DW-1:0]      o_data;
  logic               o_valid;
  logic [3:0]         ack, gnt;
  logic [1:0]         sel;
  logic               busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owning requester (-1 when idle), beats taken, rotation pointer, mux select.
  int own, beats, rptr, msel;

  rr_bus_arbiter4 #(.DW(DW), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last),
    .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
    .ack(ack), .gnt(gnt), .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    own = -1; beats = 0; rptr = 0; msel = 0;
  endtask

  task automatic check_outputs();
    logic        ev;
    logic [3:0]  eg;
    ev = (own >= 0) && req[own];
    eg = (own >= 0) ? 4'(1 << own) : 4'b0;
    chk("gnt",     32'(gnt),     32'(eg));
    chk("sel",     32'(sel),     32'(msel));
    chk("busy",    32'(busy),    32'(own >= 0));
    chk("o_valid", 32'(o_valid), 32'(ev));
    chk("ack",     32'(ack),     (ev && o_ready) ? 32'(eg) : 32'd0);
    chk("o_data",  32'(o_data),  32'(din[msel]));
  endtask

  task automatic model_step();
    if (own < 0) begin
      for (int j = 0; j < 4; j++) begin
        if (own < 0 && req[(rptr + j) % 4]) begin
          own = (rptr + j) % 4; msel = own; beats = 0;
        end
      end
    end else if (!req[own]) begin
      rptr = (own + 1) % 4; own = -1; beats = 0;
    end else if (o_ready) begin
      beats++;
      if (last[own] || beats == BURST) begin
        rptr = (own + 1) % 4; own = -1; beats = 0;
      end
    end
  endtask

  initial begin
    bit rst_pend;
    rst_n = 1'b0; req = '0; last = '0; o_ready = 1'b0; din = '0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk) rst_n = 1'b1;
    rst_pend = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rst_pend) begin rst_n = 1'b1; rst_pend = 1'b0; end
      for (int k = 0; k < 4; k++) din[k] = 16'($urandom);
      if (i < 150) begin
        req = 4'b1111; last = 4'b1111; o_ready = 1'b1;
      end else if (i < 300) begin
        req = 4'b1001; last = 4'b0000; o_ready = 1'b1;
      end else if (i < 320) begin
        req = 4'b1000; last = 4'b0000; o_ready = (i % 8) == 7;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if ($urandom_range(7) == 0) req[k] = ~req[k];
          last[k] = ($urandom_range(3) == 0);
        end
        o_ready = ($urandom_range(9) < 7);
      end
      #1 check_outputs();
      if (i > 320 && $urandom_range(149) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_gnt",     32'(gnt),     32'd0);
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_ack",     32'(ack),     32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        rst_pend = 1'b1;
      end
      @(posedge clk);
      if (!rst_pend) model_step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
